// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register bridge.
// Command byte: bit 7 selects write, bits 6:0 carry the start address.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WR,
        RD
    } spi_reg_state_t;

    localparam int          SPI_CMD_WR_BIT        = 7;
    localparam logic [7:0]  SPI_STATUS_ID_DEFAULT = 8'hA5;
    localparam int          SPI_ADDR_W            = 7;

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Register-bus interface between the SPI bridge (master) and a register file (slave).
interface spi_reg_bridge_if #(
    parameter int ADDR_W = 7
);

    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;

    modport master (
        output reg_addr,
        output reg_wdata,
        output reg_we,
        output reg_re,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr,
        input  reg_wdata,
        input  reg_we,
        input  reg_re,
        output reg_rdata
    );

endinterface

// File: rtl/spi_addr_counter.sv
// Loadable register-address counter; increments wrap silently at the top of the range.
module spi_addr_counter
    import spi_reg_pkg::*;
#(
    parameter int WIDTH = SPI_ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI byte-stream command decoder: turns a chip-select frame into register
// writes or prefetched reads with auto-incrementing addresses.
module spi_reg_bridge
    import spi_reg_pkg::*;
#(
    parameter logic [7:0] STATUS_ID = SPI_STATUS_ID_DEFAULT,
    parameter int         ADDR_W    = SPI_ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             tx_load,
    output logic [7:0]       tx_data,
    output logic             frame_err,
    spi_reg_bridge_if.master bus
);

    spi_reg_state_t    state;
    spi_reg_state_t    state_d;
    logic              frame_q;
    logic              frame_rise;
    logic              re_q;
    logic              re_d;
    logic              we_q;
    logic              we_d;
    logic              pend_q;
    logic              outstanding;
    logic              addr_load;
    logic              addr_inc;
    logic              err_set;
    logic [7:0]        wdata_q;
    logic [7:0]        tx_q;
    logic [ADDR_W-1:0] addr;

    assign frame_rise  = frame & ~frame_q;
    assign outstanding = re_q | pend_q;

    spi_addr_counter #(
        .WIDTH (ADDR_W)
    ) u_addr (
        .clk        (clk),
        .rst        (rst),
        .load       (addr_load),
        .load_value (rx_data[ADDR_W-1:0]),
        .inc        (addr_inc),
        .count      (addr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            frame_q <= 1'b0;
        end else begin
            state   <= state_d;
            frame_q <= frame;
        end
    end

    // A write advances the address the cycle after its strobe; a read advances
    // on the load and prefetches the new address, unless one is still in flight.
    always_comb begin
        state_d   = state;
        re_d      = 1'b0;
        we_d      = 1'b0;
        addr_load = 1'b0;
        addr_inc  = we_q;
        err_set   = 1'b0;
        if (!frame) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_rise) begin
                        state_d = CMD;
                    end
                end
                CMD: begin
                    if (rx_valid) begin
                        addr_load = 1'b1;
                        if (rx_data[SPI_CMD_WR_BIT]) begin
                            state_d = WR;
                        end else begin
                            state_d = RD;
                            re_d    = 1'b1;
                        end
                    end
                end
                WR: begin
                    we_d = rx_valid;
                end
                RD: begin
                    if (tx_load) begin
                        if (outstanding) begin
                            err_set = 1'b1;
                        end else begin
                            addr_inc = 1'b1;
                            re_d     = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            pend_q  <= 1'b0;
            wdata_q <= 8'h00;
        end else begin
            re_q   <= re_d;
            we_q   <= we_d;
            pend_q <= re_q & frame;
            if (we_d) begin
                wdata_q <= rx_data;
            end
        end
    end

    // Outside a read the status byte is always presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_q <= STATUS_ID;
        end else if (state_d != RD) begin
            tx_q <= STATUS_ID;
        end else if (pend_q) begin
            tx_q <= bus.reg_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err <= 1'b0;
        end else if (frame_rise) begin
            frame_err <= 1'b0;
        end else if (err_set) begin
            frame_err <= 1'b1;
        end
    end

    assign tx_data       = tx_q;
    assign bus.reg_addr  = addr;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_we    = we_q;
    assign bus.reg_re    = re_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: status byte, write/read bursts, wrap,
// frame abort, prefetch violation and asynchronous reset.
module tb_spi_reg_bridge;
    import spi_reg_pkg::*;

    logic       clk;
    logic       rst;
    logic       frame;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_load;
    logic [7:0] tx_data;
    logic       frame_err;

    int passed;
    int total;

    spi_reg_bridge_if bus ();

    spi_reg_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .frame     (frame),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_load   (tx_load),
        .tx_data   (tx_data),
        .frame_err (frame_err),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: read data is the address plus 0x40, one cycle after reg_re.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.reg_rdata <= 8'h00;
        end else if (bus.reg_re) begin
            bus.reg_rdata <= {1'b0, bus.reg_addr} + 8'h40;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        rst      = 1'b0;
        frame    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_load  = 1'b0;
        tick(2);
        check_output("rst_tx", tx_data, 32'hA5);
        check_output("rst_addr", bus.reg_addr, 32'h00);
        check_output("rst_wdata", bus.reg_wdata, 32'h00);
        check_output("rst_we", bus.reg_we, 32'h0);
        check_output("rst_re", bus.reg_re, 32'h0);
        check_output("rst_err", frame_err, 32'h0);
        rst = 1'b1;
        tick(1);

        // Status byte during the command phase
        frame = 1'b1;
        tick(1);
        tx_load = 1'b1;
        check_output("status_tx", tx_data, 32'hA5);
        tick(1);
        tx_load = 1'b0;
        check_output("status_we", bus.reg_we, 32'h0);
        check_output("status_re", bus.reg_re, 32'h0);
        check_output("status_tx_after", tx_data, 32'hA5);
        frame = 1'b0;
        tick(2);

        // Write burst at 0x10
        frame = 1'b1;
        tick(1);
        apply_stimulus(8'h90);
        apply_stimulus(8'h11);
        check_output("wr0_we", bus.reg_we, 32'h1);
        check_output("wr0_addr", bus.reg_addr, 32'h10);
        check_output("wr0_data", bus.reg_wdata, 32'h11);
        check_output("wr_tx", tx_data, 32'hA5);
        apply_stimulus(8'h22);
        check_output("wr1_we", bus.reg_we, 32'h1);
        check_output("wr1_addr", bus.reg_addr, 32'h11);
        check_output("wr1_data", bus.reg_wdata, 32'h22);
        apply_stimulus(8'h33);
        check_output("wr2_we", bus.reg_we, 32'h1);
        check_output("wr2_addr", bus.reg_addr, 32'h12);
        check_output("wr2_data", bus.reg_wdata, 32'h33);
        tick(1);
        check_output("wr_end_we", bus.reg_we, 32'h0);
        check_output("wr_end_addr", bus.reg_addr, 32'h13);
        frame = 1'b0;
        tick(2);

        // Read burst at 0x05
        frame = 1'b1;
        tick(1);
        apply_stimulus(8'h05);
        check_output("rd_cmd_re", bus.reg_re, 32'h1);
        check_output("rd_cmd_addr", bus.reg_addr, 32'h05);
        tick(2);
        check_output("rd_first_tx", tx_data, 32'h45);
        check_output("rd_first_re", bus.reg_re, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            tx_load = 1'b1;
            check_output("rd_load_tx", tx_data, 32'h45 + i);
            tick(1);
            tx_load = 1'b0;
            check_output("rd_pf_re", bus.reg_re, 32'h1);
            check_output("rd_pf_addr", bus.reg_addr, 32'h06 + i);
            tick(2);
            check_output("rd_next_tx", tx_data, 32'h46 + i);
        end
        frame = 1'b0;
        tick(1);
        check_output("rd_end_tx", tx_data, 32'hA5);
        tick(1);

        // Address wrap
        frame = 1'b1;
        tick(1);
        apply_stimulus(8'hFF);
        apply_stimulus(8'hAA);
        check_output("wrap0_we", bus.reg_we, 32'h1);
        check_output("wrap0_addr", bus.reg_addr, 32'h7F);
        apply_stimulus(8'hBB);
        check_output("wrap1_we", bus.reg_we, 32'h1);
        check_output("wrap1_addr", bus.reg_addr, 32'h00);
        check_output("wrap1_data", bus.reg_wdata, 32'hBB);
        frame = 1'b0;
        tick(2);

        // Frame dropped on the second data byte
        frame = 1'b1;
        tick(1);
        apply_stimulus(8'hA0);
        apply_stimulus(8'h01);
        check_output("abort_we0", bus.reg_we, 32'h1);
        check_output("abort_addr0", bus.reg_addr, 32'h20);
        rx_valid = 1'b1;
        rx_data  = 8'h02;
        frame    = 1'b0;
        tick(1);
        rx_valid = 1'b0;
        check_output("abort_no_we", bus.reg_we, 32'h0);
        check_output("abort_wdata", bus.reg_wdata, 32'h01);
        tick(1);
        check_output("abort_no_we2", bus.reg_we, 32'h0);
        frame = 1'b1;
        tick(1);
        check_output("abort_state", dut.state, 32'(CMD));
        check_output("abort_tx", tx_data, 32'hA5);
        frame = 1'b0;
        tick(2);

        // Early tx_load while the first prefetch is in flight
        frame = 1'b1;
        tick(1);
        apply_stimulus(8'h05);
        tick(1);
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
        check_output("err_set", frame_err, 32'h1);
        tick(3);
        check_output("err_sticky", frame_err, 32'h1);
        frame = 1'b0;
        tick(1);
        check_output("err_hold_low", frame_err, 32'h1);
        frame = 1'b1;
        tick(1);
        check_output("err_clear", frame_err, 32'h0);

        // Asynchronous reset in the middle of a read
        apply_stimulus(8'h05);
        tick(2);
        check_output("arst_pre_tx", tx_data, 32'h45);
        tick(1);
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
        check_output("arst_pre_re", bus.reg_re, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check_output("arst_tx", tx_data, 32'hA5);
        check_output("arst_addr", bus.reg_addr, 32'h00);
        check_output("arst_wdata", bus.reg_wdata, 32'h00);
        check_output("arst_we", bus.reg_we, 32'h0);
        check_output("arst_re", bus.reg_re, 32'h0);
        check_output("arst_err", frame_err, 32'h0);
        check_output("arst_state", dut.state, 32'(IDLE));
        rst   = 1'b1;
        frame = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
